mem_arbiter: RTL and testbench

Arbitrates one single-port block memory between the instruction-fetch port (IF) and the executer load/store port (EX). Each cycle it grants at most one requester, drives the memory command, tracks the outstanding read, and routes the one-cycle-latency read data back to the port that issued it. It sits between the fetch and execute stages and the `block_memory` instance, which moves out of the executer and is shared through this block.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arb_grant.sv | 50 +++++
 rtl/mem_arbiter.sv | 66 ++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/EX block-memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_EX} mem_owner_t;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/execute requesters, the arbiter and block_memory.
// master = arbiter view, slave = requesters + memory view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic              IF_VALID;
    logic [DATA_W-1:0] IF_RDATA;

    logic              EX_REQ;
    logic              EX_WE;
    logic [ADDR_W-1:0] EX_ADDR;
    logic [DATA_W-1:0] EX_WDATA;
    logic              EX_GNT;
    logic              EX_VALID;
    logic [DATA_W-1:0] EX_RDATA;

    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    modport master (
        input  IF_REQ, IF_ADDR, EX_REQ, EX_WE, EX_ADDR, EX_WDATA, MEM_RDATA,
        output IF_GNT, IF_VALID, IF_RDATA, EX_GNT, EX_VALID, EX_RDATA,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        output IF_REQ, IF_ADDR, EX_REQ, EX_WE, EX_ADDR, EX_WDATA, MEM_RDATA,
        input  IF_GNT, IF_VALID, IF_RDATA, EX_GNT, EX_VALID, EX_RDATA,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant selection between IF and EX: fixed priority EX > IF with a starvation
// override, or round robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic if_req,
    input  logic ex_req,
    output logic if_gnt,
    output logic ex_gnt
);
    logic if_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_owner_t last_gnt;

    always_ff @(posedge CLK) begin
        if (RST)         last_gnt <= OWN_IF;
        else if (ex_gnt) last_gnt <= OWN_EX;
        else if (if_gnt) last_gnt <= OWN_IF;
    end

    assign if_wins = (last_gnt == OWN_EX);
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    // Counts cycles IF waits; holding at the limit keeps the override armed.
    always_ff @(posedge CLK) begin
        if (RST)                        starve_cnt <= '0;
        else if (!if_req || if_gnt)     starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_LIMIT))
                                        starve_cnt <= starve_cnt + 1'b1;
    end

    assign if_wins = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif

    always_comb begin
        if_gnt = 1'b0;
        ex_gnt = 1'b0;
        if (!RST) begin
            if (if_req && (!ex_req || if_wins)) if_gnt = 1'b1;
            else if (ex_req)                    ex_gnt = 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port block memory between instruction fetch and load/store.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin contention policy.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    mem_arbiter_if.master bus
);
    logic              if_gnt, ex_gnt;
    logic              if_rsp, ex_rsp;
    mem_owner_t        rsp_owner;
    logic [DATA_W-1:0] if_rdata_q, ex_rdata_q;

    mem_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .CLK    (CLK),
        .RST    (RST),
        .if_req (bus.IF_REQ),
        .ex_req (bus.EX_REQ),
        .if_gnt (if_gnt),
        .ex_gnt (ex_gnt)
    );

    assign bus.IF_GNT = if_gnt;
    assign bus.EX_GNT = ex_gnt;

    always_comb begin
        bus.MEM_EN    = if_gnt | ex_gnt;
        bus.MEM_WE    = 1'b0;
        bus.MEM_ADDR  = {ADDR_W{1'b0}};
        bus.MEM_WDATA = {DATA_W{1'b0}};
        if (ex_gnt) begin
            bus.MEM_WE    = bus.EX_WE;
            bus.MEM_ADDR  = bus.EX_ADDR;
            bus.MEM_WDATA = bus.EX_WDATA;
        end else if (if_gnt) begin
            bus.MEM_ADDR  = bus.IF_ADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_owner  <= OWN_NONE;
            if_rdata_q <= '0;
            ex_rdata_q <= '0;
        end else begin
            rsp_owner <= (ex_gnt && !bus.EX_WE) ? OWN_EX :
                         if_gnt                 ? OWN_IF : OWN_NONE;
            if (rsp_owner == OWN_IF) if_rdata_q <= bus.MEM_RDATA;
            if (rsp_owner == OWN_EX) ex_rdata_q <= bus.MEM_RDATA;
        end
    end

    // Response cycle passes memory data straight through; the held copy covers
    // later cycles. Reset in the response cycle drops it entirely.
    assign if_rsp       = !RST && (rsp_owner == OWN_IF);
    assign ex_rsp       = !RST && (rsp_owner == OWN_EX);
    assign bus.IF_VALID = if_rsp;
    assign bus.EX_VALID = ex_rsp;
    assign bus.IF_RDATA = RST ? '0 : (if_rsp ? bus.MEM_RDATA : if_rdata_q);
    assign bus.EX_RDATA = RST ? '0 : (ex_rsp ? bus.MEM_RDATA : ex_rdata_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency block memory model.
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [5:0] exp_if_gnt;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bus.MEM_EN) begin
            if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
            else            bus.MEM_RDATA     <= mem[bus.MEM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic ir, input logic [AW-1:0] ia,
                       input logic er, input logic ew, input logic [AW-1:0] ea,
                       input logic [DW-1:0] ed);
        bus.IF_REQ   = ir;
        bus.IF_ADDR  = ia;
        bus.EX_REQ   = er;
        bus.EX_WE    = ew;
        bus.EX_ADDR  = ea;
        bus.EX_WDATA = ed;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        mem[1] = 32'h1111_0001;
        mem[2] = 32'h2222_0002;
        mem[5] = 32'h00A0_0093;
        mem[7] = 32'h1111_2222;
        mem[8] = 32'h3333_4444;
        bus.MEM_RDATA = '0;

        // Reset with both requests high: nothing may be granted
        RST = 1'b1;
        req(1'b1, 10'h005, 1'b1, 1'b0, 10'h003, '0);
        @(negedge CLK);
        chk("rst_if_gnt",   bus.IF_GNT,   0);
        chk("rst_ex_gnt",   bus.EX_GNT,   0);
        chk("rst_mem_en",   bus.MEM_EN,   0);
        chk("rst_if_valid", bus.IF_VALID, 0);
        chk("rst_ex_valid", bus.EX_VALID, 0);
        chk("rst_if_rdata", bus.IF_RDATA, 0);
        chk("rst_ex_rdata", bus.EX_RDATA, 0);
        tick();

        // IF alone
        RST = 1'b0;
        req(1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("if_gnt",      bus.IF_GNT,   1);
        chk("if_mem_en",   bus.MEM_EN,   1);
        chk("if_mem_addr", bus.MEM_ADDR, 32'h5);
        chk("if_mem_we",   bus.MEM_WE,   0);
        tick();
        req(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("if_valid",    bus.IF_VALID, 1);
        chk("if_rdata",    bus.IF_RDATA, 32'h00A0_0093);
        chk("if_ex_valid", bus.EX_VALID, 0);
        tick();
        @(negedge CLK);
        chk("if_valid_pulse", bus.IF_VALID, 0);
        chk("if_rdata_held",  bus.IF_RDATA, 32'h00A0_0093);
        tick();

        // EX store then load
        req(1'b0, '0, 1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF);
        @(negedge CLK);
        chk("st_gnt",   bus.EX_GNT,    1);
        chk("st_we",    bus.MEM_WE,    1);
        chk("st_wdata", bus.MEM_WDATA, 32'hDEAD_BEEF);
        chk("st_addr",  bus.MEM_ADDR,  32'h10);
        tick();
        req(1'b0, '0, 1'b1, 1'b0, 10'h010, '0);
        @(negedge CLK);
        chk("ld_gnt",         bus.EX_GNT,   1);
        chk("ld_we",          bus.MEM_WE,   0);
        chk("st_no_ex_valid", bus.EX_VALID, 0);
        tick();
        req(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("ld_valid",    bus.EX_VALID, 1);
        chk("ld_rdata",    bus.EX_RDATA, 32'hDEAD_BEEF);
        chk("ld_if_valid", bus.IF_VALID, 0);
        chk("idle_we",     bus.MEM_WE,   0);
        tick();

        // Back-to-back reads: IF then EX
        req(1'b1, 10'h007, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("b2b_if_gnt", bus.IF_GNT, 1);
        tick();
        req(1'b0, '0, 1'b1, 1'b0, 10'h008, '0);
        @(negedge CLK);
        chk("b2b_ex_gnt",   bus.EX_GNT,   1);
        chk("b2b_if_valid", bus.IF_VALID, 1);
        chk("b2b_if_rdata", bus.IF_RDATA, 32'h1111_2222);
        chk("b2b_ex_early", bus.EX_VALID, 0);
        tick();
        req(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("b2b_ex_valid", bus.EX_VALID, 1);
        chk("b2b_ex_rdata", bus.EX_RDATA, 32'h3333_4444);
        chk("b2b_if_done",  bus.IF_VALID, 0);
        tick();

        // Reset while an EX load response is pending
        req(1'b0, '0, 1'b1, 1'b0, 10'h010, '0);
        @(negedge CLK);
        chk("rmr_gnt", bus.EX_GNT, 1);
        tick();
        RST = 1'b1;
        req(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("rmr_valid1", bus.EX_VALID, 0);
        chk("rmr_rdata1", bus.EX_RDATA, 0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rmr_valid2", bus.EX_VALID, 0);
        chk("rmr_rdata2", bus.EX_RDATA, 0);
        tick();

        // Contention from reset, both requests held
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_if_gnt = 6'b101010;
`else
        exp_if_gnt = 6'b010000;
`endif
        RST = 1'b1;
        req(1'b1, 10'h001, 1'b1, 1'b0, 10'h002, '0);
        tick();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk($sformatf("cont%0d_if_gnt", c), bus.IF_GNT, exp_if_gnt[c]);
            chk($sformatf("cont%0d_ex_gnt", c), bus.EX_GNT, !exp_if_gnt[c]);
            if (c == 5) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                chk("cont5_ex_valid", bus.EX_VALID, 1);
                chk("cont5_ex_rdata", bus.EX_RDATA, 32'h2222_0002);
`else
                chk("cont5_if_valid", bus.IF_VALID, 1);
                chk("cont5_if_rdata", bus.IF_RDATA, 32'h1111_0001);
`endif
            end
            tick();
        end
        req(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
